// File: rtl/pwm_pkg.sv
// Shared PWM sizing constants and types; purely declarative.
package pwm_pkg;
  localparam int CHANNELS = 8;
  localparam int WIDTH    = 8;
  localparam int PRE_W    = 16;
  localparam int CH_W     = $clog2(CHANNELS);

  localparam logic [WIDTH-1:0] PERIOD_RST = 8'hFF;

  typedef logic [WIDTH-1:0] duty_t;
  typedef logic [PRE_W-1:0] pre_t;
  typedef logic [CH_W-1:0]  ch_t;
endpackage

// File: rtl/pwm_if.sv
// Host-side control bundle for the PWM generator: run control, duty writes, period shadow, commit.
interface pwm_if;
  import pwm_pkg::*;

  logic  enable;
  pre_t  prescale;
  logic  wr_en;
  ch_t   wr_addr;
  duty_t wr_data;
  duty_t period_in;
  logic  commit;
  logic  pending;

  modport master (
    output enable, prescale, wr_en, wr_addr, wr_data, period_in, commit,
    input  pending
  );

  modport slave (
    input  enable, prescale, wr_en, wr_addr, wr_data, period_in, commit,
    output pending
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Enable-gated clock divider: tick is combinational, one pulse every prescale+1 clocks.
// Counter is held at zero while disabled; prescale is sampled live, never stalls.
module pwm_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick,
  output logic [PRE_W-1:0] pre_cnt
);

  assign tick = enable && (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Eight phase-aligned PWM channels with double-buffered duty/period; outputs registered (1 clk after cnt).
// No backpressure: writes always accepted, commits collapse into one transfer at the next period boundary.
module pwm_generator
  import pwm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  pwm_if.slave                host,
  output logic [CHANNELS-1:0] PWM,
  output logic                period_start
);

  logic  tick;
  pre_t  pre_cnt;
  duty_t cnt;
  duty_t period_act;
  duty_t duty_sh  [CHANNELS];
  duty_t duty_act [CHANNELS];
  logic  pending_q;
  logic  boundary;
  logic  xfer;
  logic [CHANNELS-1:0] pwm_nxt;

  pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (clk),
    .reset    (reset),
    .enable   (host.enable),
    .prescale (host.prescale),
    .tick     (tick),
    .pre_cnt  (pre_cnt)
  );

  assign boundary     = tick && (cnt == period_act);
  // While stopped there is no period to protect, so transfers go through at once.
  assign xfer         = (pending_q || host.commit) && (boundary || !host.enable);
  assign host.pending = pending_q;

  always_ff @(posedge clk) begin
    if (reset || !host.enable) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else if (xfer) begin
      pending_q <= 1'b0;
    end else if (host.commit) begin
      pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_act <= PERIOD_RST;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (host.wr_en) begin
        duty_sh[host.wr_addr] <= host.wr_data;
      end
      if (xfer) begin
        period_act <= host.period_in;
        for (int i = 0; i < CHANNELS; i++) begin
          duty_act[i] <= duty_sh[i];
        end
      end
    end
  end

  always_comb begin
    pwm_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_nxt[i] = host.enable && (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PWM          <= '0;
      period_start <= 1'b0;
    end else begin
      PWM          <= pwm_nxt;
      period_start <= host.enable && (cnt == '0) && (pre_cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: hand-derived waveforms per scenario, sampled 1ns after each rising edge.
module tb_pwm_generator;
  import pwm_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [CHANNELS-1:0] pwm;
  logic                period_start;
  int                  n_checks = 0;
  int                  n_fail   = 0;

  pwm_if bus ();

  pwm_generator dut (
    .clk          (clk),
    .reset        (reset),
    .host         (bus),
    .PWM          (pwm),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.prescale  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.period_in = '0;
    bus.commit    = 1'b0;
    tick_clk;
    tick_clk;
    reset = 1'b0;
  endtask

  task automatic wr(input int ch, input int val);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(ch);
    bus.wr_data = 8'(val);
    tick_clk;
    bus.wr_en   = 1'b0;
  endtask

  task automatic commit_now;
    bus.commit = 1'b1;
    tick_clk;
    bus.commit = 1'b0;
  endtask

  task automatic go(input int pre);
    bus.prescale = 16'(pre);
    bus.enable   = 1'b1;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.prescale  = '0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd0;
    bus.wr_data   = 8'd5;
    bus.period_in = 8'd9;
    bus.commit    = 1'b1;
    tick_clk;
    tick_clk;
    n_checks++; if (pwm !== 8'h00) begin n_fail++; $display("FAIL reset_pwm got %h want 00", pwm); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps got %b want 0", period_start); end
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", bus.pending); end
    n_checks++; if (dut.period_act !== 8'hFF) begin n_fail++; $display("FAIL reset_period_act got %h want ff", dut.period_act); end
    n_checks++; if (dut.cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got %h want 00", dut.cnt); end
    n_checks++; if (dut.duty_sh[0] !== 8'h00) begin n_fail++; $display("FAIL reset_duty_sh got %h want 00", dut.duty_sh[0]); end
    do_reset;
  endtask

  task automatic test_basic;
    logic exp_p;
    logic exp_s;
    do_reset;
    bus.period_in = 8'd9;
    wr(0, 3);
    commit_now;
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL basic_idle_commit_pending got %b want 0", bus.pending); end
    n_checks++; if (dut.period_act !== 8'd9) begin n_fail++; $display("FAIL basic_idle_commit_period got %0d want 9", dut.period_act); end
    go(0);
    for (int k = 0; k < 30; k++) begin
      tick_clk;
      exp_p = (k % 10) < 3;
      exp_s = (k % 10) == 0;
      n_checks++; if (pwm[0] !== exp_p) begin n_fail++; $display("FAIL basic_pwm k=%0d got %b want %b", k, pwm[0], exp_p); end
      n_checks++; if (period_start !== exp_s) begin n_fail++; $display("FAIL basic_ps k=%0d got %b want %b", k, period_start, exp_s); end
    end
  endtask

  task automatic test_prescale;
    logic exp_p;
    logic exp_s;
    do_reset;
    bus.period_in = 8'd9;
    wr(0, 5);
    commit_now;
    go(3);
    for (int k = 0; k < 80; k++) begin
      tick_clk;
      exp_p = (k % 40) < 20;
      exp_s = (k % 40) == 0;
      n_checks++; if (pwm[0] !== exp_p) begin n_fail++; $display("FAIL prescale_pwm k=%0d got %b want %b", k, pwm[0], exp_p); end
      n_checks++; if (period_start !== exp_s) begin n_fail++; $display("FAIL prescale_ps k=%0d got %b want %b", k, period_start, exp_s); end
    end
  endtask

  task automatic test_extremes;
    logic [7:0] exp_v;
    do_reset;
    bus.period_in = 8'd9;
    wr(0, 3);
    wr(1, 0);
    wr(2, 200);
    wr(3, 9);
    wr(4, 10);
    wr(7, 255);
    commit_now;
    go(0);
    for (int k = 0; k < 30; k++) begin
      tick_clk;
      exp_v = 8'h94;
      if ((k % 10) < 3) exp_v[0] = 1'b1;
      if ((k % 10) < 9) exp_v[3] = 1'b1;
      n_checks++; if (pwm !== exp_v) begin n_fail++; $display("FAIL extremes_pwm k=%0d got %b want %b", k, pwm, exp_v); end
    end
    bus.enable = 1'b0;
    tick_clk;
    n_checks++; if (pwm !== 8'h00) begin n_fail++; $display("FAIL disable_pwm got %h want 00", pwm); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL disable_ps got %b want 0", period_start); end
    n_checks++; if (dut.cnt !== 8'h00) begin n_fail++; $display("FAIL disable_cnt got %h want 00", dut.cnt); end
  endtask

  task automatic test_midperiod;
    logic exp_p;
    logic exp_q;
    do_reset;
    bus.period_in = 8'd9;
    wr(0, 3);
    commit_now;
    go(0);
    for (int k = 0; k < 20; k++) begin
      tick_clk;
      exp_p = (k < 10) ? (k < 3) : ((k - 10) < 7);
      exp_q = (k >= 5) && (k <= 8);
      n_checks++; if (pwm[0] !== exp_p) begin n_fail++; $display("FAIL mid_pwm k=%0d got %b want %b", k, pwm[0], exp_p); end
      n_checks++; if (bus.pending !== exp_q) begin n_fail++; $display("FAIL mid_pending k=%0d got %b want %b", k, bus.pending, exp_q); end
      if (k == 3) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'd7;
      end
      if (k == 4) begin
        bus.wr_en = 1'b0; bus.commit = 1'b1;
      end
      if (k == 5) bus.commit = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic exp_p;
    logic exp_q;
    do_reset;
    bus.period_in = 8'd9;
    wr(0, 3);
    commit_now;
    wr(0, 7);
    go(0);
    for (int k = 0; k < 30; k++) begin
      tick_clk;
      if (k < 10)      exp_p = k < 3;
      else if (k < 20) exp_p = (k - 10) < 7;
      else             exp_p = (k - 20) < 1;
      exp_q = (k >= 13) && (k <= 18);
      n_checks++; if (pwm[0] !== exp_p) begin n_fail++; $display("FAIL edge_pwm k=%0d got %b want %b", k, pwm[0], exp_p); end
      n_checks++; if (bus.pending !== exp_q) begin n_fail++; $display("FAIL edge_pending k=%0d got %b want %b", k, bus.pending, exp_q); end
      if (k == 8) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'd1; bus.commit = 1'b1;
      end
      if (k == 9) begin
        bus.wr_en = 1'b0; bus.commit = 1'b0;
      end
      if (k == 12) bus.commit = 1'b1;
      if (k == 13) bus.commit = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    logic exp_s;
    do_reset;
    bus.period_in = 8'd9;
    wr(0, 3);
    commit_now;
    go(0);
    for (int k = 0; k < 5; k++) begin
      tick_clk;
      if (k == 3) begin
        n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending_before got %b want 1", bus.pending); end
      end
      if (k == 2) bus.commit = 1'b1;
      if (k == 3) bus.commit = 1'b0;
    end
    reset = 1'b1;
    tick_clk;
    n_checks++; if (pwm !== 8'h00) begin n_fail++; $display("FAIL rstmid_pwm got %h want 00", pwm); end
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending got %b want 0", bus.pending); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_ps got %b want 0", period_start); end
    n_checks++; if (dut.period_act !== 8'hFF) begin n_fail++; $display("FAIL rstmid_period_act got %h want ff", dut.period_act); end
    reset      = 1'b0;
    bus.enable = 1'b0;
    tick_clk;
    bus.enable = 1'b1;
    for (int k = 0; k < 512; k++) begin
      tick_clk;
      exp_s = (k % 256) == 0;
      n_checks++; if (pwm !== 8'h00) begin n_fail++; $display("FAIL rstmid_run_pwm k=%0d got %h want 00", k, pwm); end
      n_checks++; if (period_start !== exp_s) begin n_fail++; $display("FAIL rstmid_run_ps k=%0d got %b want %b", k, period_start, exp_s); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_prescale;
    test_extremes;
    test_midperiod;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
